div_control_unit: RTL and testbench
===================================

DIV_CONTROL_UNIT -- requirements
Module: div_control_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 4, SHALL set the operand width and the iteration count.
REQ-002 Parameter COUNT_WIDTH, default 3, SHALL set the width of the datapath iteration counter.
REQ-003 Parameter STATE_WID, default 3, SHALL set the width of the state register.
REQ-004 Port i_clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port start, input, 1: divide request, sampled only in IDLE.
REQ-007 Port z_cnt, input, 1: datapath counter is zero.
REQ-008 Port R_out, input, 1: MSB of the remainder register (1 = negative partial remainder).
REQ-009 Ports load_b, load_q, clr_Reg_r, clr_d, clr_ADD, output, 1 each: operand load and clear strobes.
REQ-010 Ports enable_r, enable_q, output, 1 each: left-shift enables for the R and Q registers.
REQ-011 Ports load_r, add_enable, shift_en_q, output, 1 each:
- load_r: capture the adder sum into R
- add_enable: 1 = subtract B, 0 = add B
- shift_en_q: capture the quotient bit
REQ-012 Ports load_cnt, clr_nn, output, 1 each:
- load_cnt = 1: decrement the counter
- clr_nn = 0: preset the counter to DATA_WIDTH
- clr_nn = 1: hold the counter
REQ-013 Ports busy, done, output, 1 each: operation in progress; one-cycle result-valid pulse.

Function
REQ-014 The FSM SHALL have exactly seven Moore states: IDLE, INIT, SHIFT, SUB, CHECK, RESTORE, DONE. All outputs SHALL be decoded from the state only.
REQ-015 IDLE SHALL assert no strobes, with busy=0 and clr_nn=1. It SHALL go to INIT when start=1, and stay in IDLE otherwise.
REQ-016 INIT SHALL assert load_b, load_q, clr_Reg_r, clr_d and clr_ADD, drive clr_nn=0, and go to SHIFT.
REQ-017 SHIFT SHALL assert enable_r, enable_q and load_cnt, and go to SUB.
REQ-018 SUB SHALL assert add_enable=1 and load_r, and go to CHECK.
REQ-019 CHECK SHALL assert shift_en_q and transition as follows:
- R_out=1 -> RESTORE
- R_out=0 and z_cnt=1 -> DONE
- otherwise -> SHIFT
REQ-020 RESTORE SHALL assert load_r with add_enable=0. It SHALL go to DONE if z_cnt=1, and to SHIFT otherwise.
REQ-021 DONE SHALL assert done for exactly one cycle and go to IDLE.
REQ-022 busy SHALL be 1 in every state except IDLE. In all states except INIT, clr_nn SHALL be 1.
REQ-023 Latency: done SHALL assert N cycles after the edge that samples start, where N = 2 + 3*DATA_WIDTH + r and r is the number of RESTORE visits.
REQ-024 start SHALL be ignored while busy=1. If start is high in DONE, the next operation SHALL begin with IDLE sampling start one cycle later.
REQ-025 Divisor zero SHALL receive no special handling: the FSM performs DATA_WIDTH iterations with no RESTORE visits.
REQ-026 Unused state encodings SHALL transition to IDLE on the next edge.

Reset
REQ-027 i_rst_n=0 SHALL immediately force IDLE. This applies at any point, including mid-operation.
REQ-028 While in reset, every output SHALL be 0 except clr_nn, which SHALL be 1.
REQ-029 After release, the first start SHALL be sampled on the first rising edge with i_rst_n=1.

Structure
REQ-030 The shared package SHALL hold:
- the DATA_WIDTH, COUNT_WIDTH and STATE_WID constants
- the state encodings: IDLE=0, INIT=1, SHIFT=2, SUB=3, CHECK=4, RESTORE=5, DONE=6
REQ-031 The block SHALL be a single module with no sub-module. It SHALL contain one state register, next-state logic and output decode.
REQ-032 A top-level integration SHALL connect each control output by its identical name to the existing datapath.

Verification
REQ-033 Dividend 13, divisor 4: RESTORE visited on iterations 1 and 2; done at N=16; quotient 0011, remainder 0001.
REQ-034 Dividend 7, divisor 0: no RESTORE; done at N=14; quotient 1111, remainder 0111.
REQ-035 Dividend 3, divisor 9: four RESTORE visits; done at N=18; quotient 0000, remainder 0011.
REQ-036 Reset pulse during the third SUB: all strobes 0 and clr_nn=1 at once. A new 13/4 run then completes correctly.
REQ-037 start toggled during busy: no restart and N unchanged. start held high through DONE: second run begins one cycle after done and gives identical results.

Source files
------------

// File: rtl/div_control_unit_pkg.sv
// Shared constants and state encodings for the restoring-divider control FSM.
package div_control_unit_pkg;

    localparam int DATA_WIDTH  = 4;
    localparam int COUNT_WIDTH = 3;
    localparam int STATE_WID   = 3;

    typedef enum logic [STATE_WID-1:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        SHIFT   = 3'd2,
        SUB     = 3'd3,
        CHECK   = 3'd4,
        RESTORE = 3'd5,
        DONE    = 3'd6
    } state_t;

endpackage

// File: rtl/div_control_unit.sv
// Moore control FSM for a restoring shift-subtract divider; every strobe is
// decoded from the current state so the datapath sees glitch-free controls.
module div_control_unit
    import div_control_unit_pkg::*;
#(
    parameter int DATA_WIDTH  = div_control_unit_pkg::DATA_WIDTH,
    parameter int COUNT_WIDTH = div_control_unit_pkg::COUNT_WIDTH,
    parameter int STATE_WID   = div_control_unit_pkg::STATE_WID
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic start,
    input  logic z_cnt,
    input  logic R_out,
    output logic load_b,
    output logic load_q,
    output logic clr_Reg_r,
    output logic clr_d,
    output logic clr_ADD,
    output logic enable_r,
    output logic enable_q,
    output logic load_r,
    output logic add_enable,
    output logic shift_en_q,
    output logic load_cnt,
    output logic clr_nn,
    output logic busy,
    output logic done
);

    // The counter is preset to DATA_WIDTH, so it must be able to hold that value.
    if (COUNT_WIDTH < $clog2(DATA_WIDTH + 1)) begin : g_bad_count_width
        $error("COUNT_WIDTH too narrow for DATA_WIDTH");
    end
    if (STATE_WID != $bits(state_t)) begin : g_bad_state_wid
        $error("STATE_WID must match the package state encoding width");
    end

    state_t state;
    state_t state_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        load_b     = 1'b0;
        load_q     = 1'b0;
        clr_Reg_r  = 1'b0;
        clr_d      = 1'b0;
        clr_ADD    = 1'b0;
        enable_r   = 1'b0;
        enable_q   = 1'b0;
        load_r     = 1'b0;
        add_enable = 1'b0;
        shift_en_q = 1'b0;
        load_cnt   = 1'b0;
        clr_nn     = 1'b1;
        busy       = 1'b1;
        done       = 1'b0;

        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = INIT;
                end
            end
            INIT: begin
                load_b    = 1'b1;
                load_q    = 1'b1;
                clr_Reg_r = 1'b1;
                clr_d     = 1'b1;
                clr_ADD   = 1'b1;
                clr_nn    = 1'b0;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                enable_r  = 1'b1;
                enable_q  = 1'b1;
                load_cnt  = 1'b1;
                state_nxt = SUB;
            end
            SUB: begin
                load_r     = 1'b1;
                add_enable = 1'b1;
                state_nxt  = CHECK;
            end
            CHECK: begin
                shift_en_q = 1'b1;
                // A negative partial remainder must be undone before finishing.
                if (R_out) begin
                    state_nxt = RESTORE;
                end else if (z_cnt) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = SHIFT;
                end
            end
            RESTORE: begin
                load_r    = 1'b1;
                state_nxt = z_cnt ? DONE : SHIFT;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_div_control_unit.sv
// Directed bench: a behavioural restoring-divider datapath closes the loop
// around the FSM; strobes, latency and quotient/remainder are checked.
module tb_div_control_unit;

    localparam int W = 4;

    localparam logic [13:0] V_IDLE    = 14'b00000_00_000_01_00;
    localparam logic [13:0] V_INIT    = 14'b11111_00_000_00_10;
    localparam logic [13:0] V_SHIFT   = 14'b00000_11_000_11_10;
    localparam logic [13:0] V_SUB     = 14'b00000_00_110_01_10;
    localparam logic [13:0] V_CHECK   = 14'b00000_00_001_01_10;
    localparam logic [13:0] V_RESTORE = 14'b00000_00_100_01_10;
    localparam logic [13:0] V_DONE    = 14'b00000_00_000_01_11;

    logic clk = 1'b0;
    logic i_rst_n = 1'b0;
    logic start = 1'b0;
    logic z_cnt, R_out;
    logic load_b, load_q, clr_Reg_r, clr_d, clr_ADD, enable_r, enable_q;
    logic load_r, add_enable, shift_en_q, load_cnt, clr_nn, busy, done;

    logic [W-1:0] dividend_in = '0;
    logic [W-1:0] divisor_in  = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] q = '0;
    logic [W:0]   r = '0;
    logic [2:0]   cnt = '0;

    logic [13:0] ovec;
    logic [13:0] trace [0:63];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    div_control_unit dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .start(start), .z_cnt(z_cnt), .R_out(R_out),
        .load_b(load_b), .load_q(load_q), .clr_Reg_r(clr_Reg_r), .clr_d(clr_d),
        .clr_ADD(clr_ADD), .enable_r(enable_r), .enable_q(enable_q), .load_r(load_r),
        .add_enable(add_enable), .shift_en_q(shift_en_q), .load_cnt(load_cnt),
        .clr_nn(clr_nn), .busy(busy), .done(done)
    );

    assign ovec = {load_b, load_q, clr_Reg_r, clr_d, clr_ADD, enable_r, enable_q,
                   load_r, add_enable, shift_en_q, load_cnt, clr_nn, busy, done};

    // Restoring-division datapath driven purely by the FSM strobes.
    assign R_out = r[W];
    assign z_cnt = (cnt == 3'd0);

    always @(posedge clk) begin
        if (!clr_nn) cnt <= 3'(W);
        else if (load_cnt) cnt <= cnt - 3'd1;
        if (load_b) b <= divisor_in;
        if (clr_Reg_r) r <= '0;
        else if (enable_r) r <= {r[W-1:0], q[W-1]};
        else if (load_r) r <= add_enable ? r - {1'b0, b} : r + {1'b0, b};
        if (load_q) q <= dividend_in;
        else if (enable_q) q <= {q[W-2:0], 1'b0};
        else if (shift_en_q) q[0] <= ~r[W];
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Called at a falling edge. Latency counts rising edges from the one that
    // samples start through the one that raises done, both inclusive.
    task automatic run_div(input string tag, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                           input int exp_n, input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                           input bit toggle, input bit hold);
        int n;
        bit seen;
        dividend_in = dvd;
        divisor_in  = dvs;
        start = 1'b1;
        @(posedge clk);
        n = 1;
        seen = 1'b0;
        #1 start = toggle ? 1'b0 : hold;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (n <= 64) trace[n-1] = ovec;
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            n++;
            if (toggle) begin
                #1 start = n[0];
            end
        end
        check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
        check_eq({tag, "_latency"}, n, exp_n);
        check_eq({tag, "_quotient"}, 32'(q), 32'(exp_q));
        check_eq({tag, "_remainder"}, 32'(r), 32'(exp_r));
        if (toggle) start = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outputs", 32'(ovec), 32'(V_IDLE));
        i_rst_n = 1'b1;

        @(negedge clk);
        check_eq("idle_no_start", 32'(ovec), 32'(V_IDLE));

        run_div("d13_4", 4'd13, 4'd4, 16, 4'b0011, 4'b0001, 1'b0, 1'b0);
        check_eq("d13_4_init",    32'(trace[0]), 32'(V_INIT));
        check_eq("d13_4_shift",   32'(trace[1]), 32'(V_SHIFT));
        check_eq("d13_4_sub",     32'(trace[2]), 32'(V_SUB));
        check_eq("d13_4_check",   32'(trace[3]), 32'(V_CHECK));
        check_eq("d13_4_restore", 32'(trace[4]), 32'(V_RESTORE));
        check_eq("d13_4_shift2",  32'(trace[5]), 32'(V_SHIFT));
        check_eq("d13_4_done",    32'(trace[15]), 32'(V_DONE));
        @(negedge clk);
        check_eq("d13_4_back_idle", 32'(ovec), 32'(V_IDLE));

        run_div("d7_0", 4'd7, 4'd0, 14, 4'b1111, 4'b0111, 1'b0, 1'b0);
        check_eq("d7_0_no_restore", 32'(trace[4]), 32'(V_SHIFT));
        @(negedge clk);

        run_div("d3_9", 4'd3, 4'd9, 18, 4'b0000, 4'b0011, 1'b0, 1'b0);
        @(negedge clk);

        // Asynchronous reset in the middle of the third SUB.
        dividend_in = 4'd13;
        divisor_in  = 4'd4;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 check_eq("rst_pre_sub", 32'(ovec), 32'(V_SUB));
        i_rst_n = 1'b0;
        #1 check_eq("rst_immediate", 32'(ovec), 32'(V_IDLE));
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_held", 32'(ovec), 32'(V_IDLE));
        i_rst_n = 1'b1;
        run_div("post_rst", 4'd13, 4'd4, 16, 4'b0011, 4'b0001, 1'b0, 1'b0);
        @(negedge clk);

        run_div("toggle", 4'd13, 4'd4, 16, 4'b0011, 4'b0001, 1'b1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_eq("toggle_no_restart", 32'(busy), 32'd0);

        run_div("hold1", 4'd13, 4'd4, 16, 4'b0011, 4'b0001, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check_eq("hold_idle_gap", 32'(ovec), 32'(V_IDLE));
        run_div("hold2", 4'd13, 4'd4, 16, 4'b0011, 4'b0001, 1'b0, 1'b0);
        check_eq("hold2_init", 32'(trace[0]), 32'(V_INIT));
        @(negedge clk);
        check_eq("hold2_idle", 32'(ovec), 32'(V_IDLE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
